pipeline_hazard_ctrl: RTL and testbench

//  Central hazard/sequencing controller for the 5-stage RV32I pipeline. Computes EX operand

---
 rtl/pipeline_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: EX forwarding, load-use bubbles,
// branch/jump flushes, data-memory wait freeze with timeout, and stall/flush event counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_rs1,
    input  logic [4:0]       if_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_pc_src,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_we,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_we,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             stall_back,
    output logic             flush_fetch,
    output logic             flush_decode,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    // The stall cycle spent in RUN counts toward the timeout, so the counter enters MEM_WAIT at 1.
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic              load_use_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    function automatic logic [1:0] fwd_sel(
        input logic       m_we,
        input logic [4:0] m_rd,
        input logic       w_we,
        input logic [4:0] w_rd,
        input logic [4:0] rs
    );
        logic [1:0] sel;
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            sel = 2'b10;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Operand forwarding selects and load-use detection
    always_comb begin
        forward_a  = fwd_sel(mem_reg_we, mem_rd, wb_reg_we, wb_rd, ex_rs1);
        forward_b  = fwd_sel(mem_reg_we, mem_rd, wb_reg_we, wb_rd, ex_rs2);
        load_use_s = ex_is_load && (ex_rd != 5'd0) && ((ex_rd == if_rs1) || (ex_rd == if_rs2));
    end

    // State and wait-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Next-state and wait-counter logic
    always_comb begin
        state_nxt_s    = ST_RUN;
        wait_cnt_nxt_s = '0;
        case (state_r)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    state_nxt_s    = ST_MEM_WAIT;
                    wait_cnt_nxt_s = WAIT_W'(1);
                end else begin
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready || (wait_cnt_r == WAIT_MAX)) begin
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s    = ST_MEM_WAIT;
                    wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            default: begin
                state_nxt_s    = ST_RUN;
                wait_cnt_nxt_s = '0;
            end
        endcase
    end

    // Stall/flush/timeout outputs; memory wait beats redirect, redirect beats load-use
    always_comb begin
        stall_fetch  = 1'b0;
        stall_decode = 1'b0;
        stall_back   = 1'b0;
        flush_fetch  = 1'b0;
        flush_decode = 1'b0;
        mem_timeout  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    stall_fetch  = 1'b1;
                    stall_decode = 1'b1;
                    stall_back   = 1'b1;
                end else if (ex_pc_src) begin
                    flush_fetch  = 1'b1;
                    flush_decode = 1'b1;
                end else if (load_use_s) begin
                    stall_fetch  = 1'b1;
                    stall_decode = 1'b1;
                    flush_decode = 1'b1;
                end else begin
                    stall_fetch  = 1'b0;
                end
            end
            ST_MEM_WAIT: begin
                stall_fetch  = 1'b1;
                stall_decode = 1'b1;
                stall_back   = 1'b1;
                mem_timeout  = !mem_ready && (wait_cnt_r == WAIT_MAX);
            end
            default: begin
                stall_fetch  = 1'b0;
            end
        endcase
    end

    // Performance counters, wrapping modulo 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, stall_fetch};
            flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, (flush_fetch | flush_decode)};
        end
    end

    assign stall_cycles = stall_cnt_r;
    assign flush_events = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with a shortened memory timeout of 8 cycles.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  if_rs1, if_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        ex_is_load, ex_pc_src, mem_reg_we, mem_req, mem_ready, wb_reg_we;
    logic [1:0]  forward_a, forward_b;
    logic        stall_fetch, stall_decode, stall_back, flush_fetch, flush_decode, mem_timeout;
    logic [31:0] stall_cycles, flush_events;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [5:0]  ctl;   // {stall_fetch, stall_decode, stall_back, flush_fetch, flush_decode, mem_timeout}
        logic [31:0] scyc;
        logic [31:0] fev;
    } exp_t;

    exp_t exp_q[$];
    logic [31:0] ref_stall = 32'd0;
    logic [31:0] ref_flush = 32'd0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_rs1(if_rs1), .if_rs2(if_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_pc_src(ex_pc_src),
        .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_back(stall_back),
        .flush_fetch(flush_fetch), .flush_decode(flush_decode), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (mem_reg_we && mem_rd == rs && rs != 5'd0) return 2'b10;
        if (wb_reg_we && wb_rd == rs && rs != 5'd0) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clr();
        if_rs1 = 5'd0; if_rs2 = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0;
        mem_rd = 5'd0; wb_rd = 5'd0; ex_is_load = 1'b0; ex_pc_src = 1'b0;
        mem_reg_we = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; wb_reg_we = 1'b0;
    endtask

    // Inputs are already driven; push expectation, compare mid-cycle, then advance one clock.
    task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [5:0] ctl);
        exp_t e, o;
        e.fa = fa; e.fb = fb; e.ctl = ctl; e.scyc = ref_stall; e.fev = ref_flush;
        exp_q.push_back(e);
        @(negedge clk);
        o = exp_q.pop_front();
        chk({tag, ".fwd_a"}, 32'(forward_a), 32'(o.fa));
        chk({tag, ".fwd_b"}, 32'(forward_b), 32'(o.fb));
        chk({tag, ".ctl"}, 32'({stall_fetch, stall_decode, stall_back,
                                flush_fetch, flush_decode, mem_timeout}), 32'(o.ctl));
        chk({tag, ".stall_cycles"}, stall_cycles, o.scyc);
        chk({tag, ".flush_events"}, flush_events, o.fev);
        if (rst) begin
            ref_stall = 32'd0;
            ref_flush = 32'd0;
        end else begin
            ref_stall = ref_stall + 32'(o.ctl[5]);
            ref_flush = ref_flush + 32'(o.ctl[2] | o.ctl[1]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        step("reset", 2'b00, 2'b00, 6'b000000);

        // Forwarding priority
        ex_rs1 = 5'd7; ex_rs2 = 5'd3; mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_we = 1'b1; wb_reg_we = 1'b1;
        step("fwd_both", 2'b10, 2'b00, 6'b000000);
        mem_reg_we = 1'b0;
        step("fwd_wb", 2'b01, 2'b00, 6'b000000);
        mem_reg_we = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0;
        step("fwd_x0", 2'b00, 2'b00, 6'b000000);
        ex_rs2 = 5'd9; mem_rd = 5'd9; wb_rd = 5'd9; ex_rs1 = 5'd9;
        step("fwd_b_mem", 2'b10, 2'b10, 6'b000000);
        for (int i = 0; i < 20; i++) begin
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            mem_rd = 5'($urandom_range(0, 3)); wb_rd  = 5'($urandom_range(0, 3));
            mem_reg_we = 1'($urandom_range(0, 1)); wb_reg_we = 1'($urandom_range(0, 1));
            step("fwd_rand", fwd_ref(ex_rs1), fwd_ref(ex_rs2), 6'b000000);
        end
        clr();

        // Load-use: one bubble, then released
        ex_is_load = 1'b1; ex_rd = 5'd5; if_rs1 = 5'd5; if_rs2 = 5'd1;
        step("lu_rs1", 2'b00, 2'b00, 6'b110010);
        ex_is_load = 1'b0;
        step("lu_done", 2'b00, 2'b00, 6'b000000);
        ex_is_load = 1'b1; ex_rd = 5'd4; if_rs1 = 5'd2; if_rs2 = 5'd4;
        step("lu_rs2", 2'b00, 2'b00, 6'b110010);
        ex_rd = 5'd0; if_rs1 = 5'd0; if_rs2 = 5'd0;
        step("lu_x0", 2'b00, 2'b00, 6'b000000);

        // Redirect beats load-use
        ex_rd = 5'd5; if_rs1 = 5'd5; ex_pc_src = 1'b1;
        step("redirect", 2'b00, 2'b00, 6'b000110);
        clr();
        step("post_redir", 2'b00, 2'b00, 6'b000000);

        // Memory wait: 3 not-ready cycles then ready; redirect ignored while frozen
        mem_req = 1'b1; mem_ready = 1'b0; ex_pc_src = 1'b1;
        step("mw_run", 2'b00, 2'b00, 6'b111000);
        step("mw_w1", 2'b00, 2'b00, 6'b111000);
        step("mw_w2", 2'b00, 2'b00, 6'b111000);
        mem_ready = 1'b1;
        step("mw_ready", 2'b00, 2'b00, 6'b111000);
        clr();
        step("mw_back", 2'b00, 2'b00, 6'b000000);

        // Timeout: pulse on the 8th stall cycle
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 1; i <= 7; i++) step("to_wait", 2'b00, 2'b00, 6'b111000);
        step("to_pulse", 2'b00, 2'b00, 6'b111001);
        clr();
        step("to_back", 2'b00, 2'b00, 6'b000000);

        // Reset during the second MEM_WAIT cycle
        mem_req = 1'b1; mem_ready = 1'b0;
        step("rw_run", 2'b00, 2'b00, 6'b111000);
        step("rw_w1", 2'b00, 2'b00, 6'b111000);
        rst = 1'b1;
        step("rw_rst", 2'b00, 2'b00, 6'b111000);
        rst = 1'b0; mem_req = 1'b0;
        step("rw_after", 2'b00, 2'b00, 6'b000000);
        step("rw_idle", 2'b00, 2'b00, 6'b000000);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
